// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator, MSB first, one bit per clock.
// Ports: clk, rst, start, a, b, signed_mode -> busy, done, gt, eq, lt, cycles.
module serial_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sm_q;
  logic [IW-1:0]    idx;
  logic             decided;
  logic             d_gt;
  logic [CW-1:0]    cnt;

  logic bit_a;
  logic bit_b;
  logic new_diff;
  logic bit_gt;
  logic stop;

  assign bit_a    = a_q[idx];
  assign bit_b    = b_q[idx];
  assign new_diff = (bit_a ^ bit_b) & ~decided;
  // The sign bit carries negative weight, so a 1 there means smaller.
  assign bit_gt   = (idx == TOP && sm_q) ? bit_b : bit_a;
  assign stop     = (idx == '0) | ((EARLY_EXIT != 0) & new_diff);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      idx     <= '0;
      decided <= 1'b0;
      d_gt    <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
      cycles  <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sm_q    <= signed_mode;
            idx     <= TOP;
            decided <= 1'b0;
            d_gt    <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          idx <= idx - IW'(1);
          if (new_diff) begin
            decided <= 1'b1;
            d_gt    <= bit_gt;
          end
          if (stop) begin
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
            cycles <= cnt + CW'(1);
            if (new_diff) begin
              gt <= bit_gt;
              eq <= 1'b0;
              lt <= ~bit_gt;
            end else if (decided) begin
              gt <= d_gt;
              eq <= 1'b0;
              lt <= ~d_gt;
            end else begin
              gt <= 1'b0;
              eq <= 1'b1;
              lt <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: early-exit, full-scan and 2-bit builds.
// Directed scenarios plus random operands against an arithmetic model.
module tb_serial_mag_comparator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sm;

  logic       busy_e, done_e, gt_e, eq_e, lt_e;
  logic [3:0] cyc_e;
  logic       busy_f, done_f, gt_f, eq_f, lt_f;
  logic [3:0] cyc_f;

  logic       start2;
  logic [1:0] a2;
  logic [1:0] b2;
  logic       sm2;
  logic       busy_2, done_2, gt_2, eq_2, lt_2;
  logic [1:0] cyc_2;

  int errs   = 0;
  int checks = 0;

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(1)) u_ee (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .signed_mode(sm), .busy(busy_e), .done(done_e),
    .gt(gt_e), .eq(eq_e), .lt(lt_e), .cycles(cyc_e)
  );

  serial_mag_comparator #(.WIDTH(8), .EARLY_EXIT(0)) u_fs (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .signed_mode(sm), .busy(busy_f), .done(done_f),
    .gt(gt_f), .eq(eq_f), .lt(lt_f), .cycles(cyc_f)
  );

  serial_mag_comparator #(.WIDTH(2), .EARLY_EXIT(0)) u_w2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .signed_mode(sm2), .busy(busy_2), .done(done_2),
    .gt(gt_2), .eq(eq_2), .lt(lt_2), .cycles(cyc_2)
  );

  // Reference: plain integer compare; early exit stops at the highest
  // differing bit, so bits examined = 8 - position of that bit.
  function automatic void model(input logic [7:0] x, input logic [7:0] y,
                                input bit s, input bit ee,
                                output logic [2:0] f, output int cyc);
    int xi;
    int yi;
    logic [7:0] d;
    if (s) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    f = {xi > yi, xi == yi, xi < yi};
    d = x ^ y;
    cyc = 8;
    if (ee && d != 0) begin
      for (int p = 0; p < 8; p++)
        if (d[p]) cyc = 8 - p;
    end
  endfunction

  // Drives one compare into both 8-bit builds and observes them.
  task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit s,
                      output logic [2:0] fe, output int ce, output int le,
                      output logic [2:0] ff, output int cf, output int lf,
                      output int busy_n, output int done_n);
    @(negedge clk);
    a = x; b = y; sm = s; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
    le = -1; lf = -1; ce = -1; cf = -1; fe = '0; ff = '0;
    done_n = 0;
    busy_n = busy_e ? 1 : 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if (busy_e) busy_n++;
      if (done_e) begin
        done_n++;
        if (le < 0) begin
          le = n; fe = {gt_e, eq_e, lt_e}; ce = int'(cyc_e);
        end
      end
      if (done_f && lf < 0) begin
        lf = n; ff = {gt_f, eq_f, lt_f}; cf = int'(cyc_f);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; sm = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; sm2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_e, done_e, gt_e, eq_e, lt_e, cyc_e} !== 9'h0) begin
      errs++;
      $display("FAIL reset_ee got=%h want=0",
               {busy_e, done_e, gt_e, eq_e, lt_e, cyc_e});
    end
    checks++;
    if ({busy_f, done_f, gt_f, eq_f, lt_f, cyc_f} !== 9'h0) begin
      errs++;
      $display("FAIL reset_fs got=%h want=0",
               {busy_f, done_f, gt_f, eq_f, lt_f, cyc_f});
    end
    checks++;
    if ({busy_2, done_2, gt_2, eq_2, lt_2, cyc_2} !== 7'h0) begin
      errs++;
      $display("FAIL reset_w2 got=%h want=0",
               {busy_2, done_2, gt_2, eq_2, lt_2, cyc_2});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_equality;
    logic [2:0] fe, ff;
    int ce, le, cf, lf, bn, dn;
    run8(8'hA5, 8'hA5, 1'b0, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ce[3:0], le[3:0]} !== {3'b010, 4'd8, 4'd8}) begin
      errs++;
      $display("FAIL eq_ee flags/cyc/lat got=%b/%0d/%0d want=010/8/8",
               fe, ce, le);
    end
    checks++;
    if ({ff, cf[3:0], lf[3:0]} !== {3'b010, 4'd8, 4'd8}) begin
      errs++;
      $display("FAIL eq_fs flags/cyc/lat got=%b/%0d/%0d want=010/8/8",
               ff, cf, lf);
    end
    checks++;
    if (bn !== 8 || dn !== 1) begin
      errs++;
      $display("FAIL eq_pulses busy=%0d done=%0d want busy=8 done=1",
               bn, dn);
    end
  endtask

  task automatic test_early_exit;
    logic [2:0] fe, ff;
    int ce, le, cf, lf, bn, dn;
    run8(8'h80, 8'h7F, 1'b0, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ce[3:0], le[3:0]} !== {3'b100, 4'd1, 4'd1}) begin
      errs++;
      $display("FAIL ee_80_7f got=%b/%0d/%0d want=100/1/1", fe, ce, le);
    end
    checks++;
    if ({ff, cf[3:0], lf[3:0]} !== {3'b100, 4'd8, 4'd8}) begin
      errs++;
      $display("FAIL fs_80_7f got=%b/%0d/%0d want=100/8/8", ff, cf, lf);
    end
    run8(8'h12, 8'h13, 1'b0, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ce[3:0], le[3:0]} !== {3'b001, 4'd8, 4'd8}) begin
      errs++;
      $display("FAIL ee_12_13 got=%b/%0d/%0d want=001/8/8", fe, ce, le);
    end
    checks++;
    if ({ff, cf[3:0], lf[3:0]} !== {3'b001, 4'd8, 4'd8}) begin
      errs++;
      $display("FAIL fs_12_13 got=%b/%0d/%0d want=001/8/8", ff, cf, lf);
    end
  endtask

  task automatic test_signed;
    logic [2:0] fe, ff;
    int ce, le, cf, lf, bn, dn;
    run8(8'h80, 8'h7F, 1'b1, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ce[3:0], le[3:0]} !== {3'b001, 4'd1, 4'd1}) begin
      errs++;
      $display("FAIL sgn_ee_80_7f got=%b/%0d/%0d want=001/1/1", fe, ce, le);
    end
    checks++;
    if ({ff, cf[3:0]} !== {3'b001, 4'd8}) begin
      errs++;
      $display("FAIL sgn_fs_80_7f got=%b/%0d want=001/8", ff, cf);
    end
    run8(8'hFF, 8'hFE, 1'b1, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ce[3:0], ff, cf[3:0]} !== {3'b100, 4'd8, 3'b100, 4'd8}) begin
      errs++;
      $display("FAIL sgn_ff_fe got=%b/%0d %b/%0d want=100/8 100/8",
               fe, ce, ff, cf);
    end
    run8(8'hFF, 8'hFE, 1'b0, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ff} !== {3'b100, 3'b100}) begin
      errs++;
      $display("FAIL uns_ff_fe got=%b %b want=100 100", fe, ff);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [2:0] fe, ff;
    int ce, le, cf, lf, bn, dn, extra;
    @(negedge clk);
    a = 8'h12; b = 8'h13; sm = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy_e, done_e, gt_e, eq_e, lt_e, cyc_e,
         busy_f, done_f, gt_f, eq_f, lt_f, cyc_f} !== 18'h0) begin
      errs++;
      $display("FAIL rst_mid_run got=%h want=0",
               {busy_e, done_e, gt_e, eq_e, lt_e, cyc_e,
                busy_f, done_f, gt_f, eq_f, lt_f, cyc_f});
    end
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk);
      #1;
      if (done_e || done_f) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errs++;
      $display("FAIL rst_no_done got=%0d done cycles want=0", extra);
    end
    run8(8'h12, 8'h13, 1'b0, fe, ce, le, ff, cf, lf, bn, dn);
    checks++;
    if ({fe, ce[3:0], ff, cf[3:0]} !== {3'b001, 4'd8, 3'b001, 4'd8}) begin
      errs++;
      $display("FAIL rst_recover got=%b/%0d %b/%0d want=001/8 001/8",
               fe, ce, ff, cf);
    end
  endtask

  task automatic test_start_mid_run;
    logic [2:0] f;
    int lat, cyc, dn;
    @(negedge clk);
    a = 8'h12; b = 8'h13; sm = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1; cyc = -1; dn = 0; f = '0;
    for (int n = 5; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (done_f) begin
        dn++;
        if (lat < 0) begin
          lat = n; f = {gt_f, eq_f, lt_f}; cyc = int'(cyc_f);
        end
      end
    end
    checks++;
    if ({f, cyc[3:0], lat[3:0], dn[1:0]} !==
        {3'b001, 4'd8, 4'd8, 2'd1}) begin
      errs++;
      $display("FAIL start_mid_run got=%b/%0d/%0d/%0d want=001/8/8/1",
               f, cyc, lat, dn);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] f1, f2;
    int n1, n2, c1, c2, hold_bad;
    @(negedge clk);
    a = 8'h80; b = 8'h7F; sm = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 8'h12; b = 8'h13;
    n1 = -1; n2 = -1; c1 = -1; c2 = -1; f1 = '0; f2 = '0;
    hold_bad = 0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (done_e) begin
        if (n1 < 0) begin
          n1 = n; f1 = {gt_e, eq_e, lt_e}; c1 = int'(cyc_e);
        end else if (n2 < 0) begin
          n2 = n; f2 = {gt_e, eq_e, lt_e}; c2 = int'(cyc_e);
        end
      end else if (n1 > 0 && n2 < 0) begin
        if ({gt_e, eq_e, lt_e} !== 3'b100 || cyc_e !== 4'd1)
          hold_bad++;
      end
      if (n == 2) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    checks++;
    if ({f1, c1[3:0], n1[3:0]} !== {3'b100, 4'd1, 4'd1}) begin
      errs++;
      $display("FAIL b2b_first got=%b/%0d/%0d want=100/1/1", f1, c1, n1);
    end
    checks++;
    if ({f2, c2[3:0]} !== {3'b001, 4'd8}) begin
      errs++;
      $display("FAIL b2b_second got=%b/%0d want=001/8", f2, c2);
    end
    checks++;
    if (n2 - n1 !== 9) begin
      errs++;
      $display("FAIL b2b_gap got=%0d want=9", n2 - n1);
    end
    checks++;
    if (hold_bad !== 0) begin
      errs++;
      $display("FAIL b2b_hold got=%0d changed samples want=0", hold_bad);
    end
  endtask

  task automatic test_random;
    logic [2:0] fe, ff, xe, xf;
    int ce, le, cf, lf, bn, dn, me, mf;
    logic [7:0] x, y;
    bit s;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      y = (i % 4 == 0) ? x ^ 8'(1 << (i % 8)) : 8'($urandom);
      if (i % 10 == 3) y = x;
      s = 1'($urandom);
      model(x, y, s, 1'b1, xe, me);
      model(x, y, s, 1'b0, xf, mf);
      run8(x, y, s, fe, ce, le, ff, cf, lf, bn, dn);
      checks++;
      if (fe !== xe || ce !== me || le !== me) begin
        errs++;
        $display("FAIL rand_ee a=%h b=%h s=%0d got=%b/%0d/%0d want=%b/%0d/%0d",
                 x, y, s, fe, ce, le, xe, me, me);
      end
      checks++;
      if (ff !== xf || cf !== mf || lf !== mf) begin
        errs++;
        $display("FAIL rand_fs a=%h b=%h s=%0d got=%b/%0d/%0d want=%b/%0d/%0d",
                 x, y, s, ff, cf, lf, xf, mf, mf);
      end
    end
  endtask

  task automatic test_exhaustive_w2;
    logic [2:0] f, w;
    int lat, cyc;
    logic [1:0] x, y;
    for (int i = 0; i < 16; i++) begin
      x = 2'(i >> 2);
      y = 2'(i);
      w = {x > y, x == y, x < y};
      @(negedge clk);
      a2 = x; b2 = y; start2 = 1'b1;
      @(posedge clk);
      lat = -1; cyc = -1; f = '0;
      for (int n = 1; n <= 4; n++) begin
        @(posedge clk);
        #1;
        if (done_2) begin
          lat = n; f = {gt_2, eq_2, lt_2}; cyc = int'(cyc_2);
          break;
        end
      end
      checks++;
      if (f !== w || cyc !== 2 || lat !== 2) begin
        errs++;
        $display("FAIL w2 a=%0d b=%0d got=%b/%0d/%0d want=%b/2/2",
                 x, y, f, cyc, lat, w);
      end
    end
    @(negedge clk);
    start2 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_equality;
    test_early_exit;
    test_signed;
    test_reset_mid_run;
    test_start_mid_run;
    test_back_to_back;
    test_random;
    test_exhaustive_w2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
